elelock_ctrl: RTL and testbench

Sequencing controller for the tenkey electronic lock. It collects digit presses into a code buffer and compares the code on `enter` against a programmable secret. It drives `lock`, counts failed attempts, enforces a lockout period, and auto-relocks after a hold time. It sits between the debounced tenkey pad and the door actuator, replacing the free-running two-digit compare with a supervised entry sequence.

---
 rtl/elelock_pkg.sv | 28 ++
 rtl/elelock_keyenc.sv | 16 +
 rtl/elelock_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_elelock_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elelock_pkg.sv
// elelock_pkg -- shared definitions for the tenkey lock controller.
//   state_t          FSM encoding (also visible on elelock_ctrl.state_o)
//   DIGIT_W          width of one decimal digit in the code buffer
//   NO_KEY           digit value returned for "no valid key"
//   onehot_to_digit  tenkey one-hot vector -> digit, NO_KEY if not one-hot
package elelock_pkg;

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROGRAM = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] NO_KEY = 4'hF;

  function automatic logic [DIGIT_W-1:0] onehot_to_digit(input logic [9:0] k);
    logic [DIGIT_W-1:0] d;
    d = NO_KEY;
    for (int i = 0; i < 10; i++) begin
      if (k == (10'b1 << i)) d = DIGIT_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/elelock_keyenc.sv
// elelock_keyenc -- combinational tenkey decoder.
//   tenkey  in  10  one-hot key press
//   valid   out 1   exactly one key bit set
//   digit   out 4   decoded digit 0..9 (NO_KEY when not valid)
module elelock_keyenc
  import elelock_pkg::*;
(
  input  logic [9:0]         tenkey,
  output logic               valid,
  output logic [DIGIT_W-1:0] digit
);

  assign digit = onehot_to_digit(tenkey);
  assign valid = (digit != NO_KEY);

endmodule

// File: rtl/elelock_ctrl.sv
// elelock_ctrl -- supervised code-entry controller for the tenkey lock.
//   clk       in   clock, rising edge
//   rst_n     in   synchronous reset, active low
//   tenkey    in   one-hot key press, one cycle per press
//   enter     in   pulse: submit buffered code
//   close     in   level: request lock / abort
//   prog      in   pulse: start secret programming (OPEN only)
//   lock      out  1 = locked
//   lockout   out  1 = lockout active, inputs ignored
//   fail_cnt  out  consecutive failed entries
//   state_o   out  current FSM state
//
// state     | meaning
// LOCKED    | idle and locked, waiting for the first digit
// ENTRY     | collecting digits, inactivity timer running
// OPEN      | unlocked, relock timer running
// PROGRAM   | unlocked, collecting a new secret
// LOCKOUT   | too many failures, everything ignored until timer expires
module elelock_ctrl
  import elelock_pkg::*;
#(
  parameter int                         DIGITS      = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]  SECRET_INIT = 16'h7341,
  parameter int                         MAX_FAIL    = 3,
  parameter int                         LOCKOUT_CYC = 1000,
  parameter int                         RELOCK_CYC  = 500,
  parameter int                         TIMEOUT_CYC = 200
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [9:0]                      tenkey,
  input  logic                            enter,
  input  logic                            close,
  input  logic                            prog,
  output logic                            lock,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic [2:0]                      state_o
);

  localparam int BUF_W   = DIGITS * DIGIT_W;
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int CNT_W   = $clog2(DIGITS + 2);
  localparam int TMR_MAX = (LOCKOUT_CYC > RELOCK_CYC)
                           ? ((LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC)
                           : ((RELOCK_CYC > TIMEOUT_CYC) ? RELOCK_CYC : TIMEOUT_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Terminal counts: the timer is 0 in the first cycle of a state, so the
  // transition fires on the edge where it holds CYC-1.
  localparam logic [TMR_W-1:0]  TC_TIMEOUT = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  TC_RELOCK  = TMR_W'(RELOCK_CYC - 1);
  localparam logic [TMR_W-1:0]  TC_LOCKOUT = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_OVF    = CNT_W'(DIGITS + 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

  state_t               state;
  logic [BUF_W-1:0]     code_buf;
  logic [BUF_W-1:0]     secret;
  logic [BUF_W-1:0]     buf_shift;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [TMR_W-1:0]     tmr;
  logic [TMR_W-1:0]     tmr_inc;
  logic [FAIL_W-1:0]    fail_inc;
  logic                 key_valid;
  logic [DIGIT_W-1:0]   key_digit;
  logic                 code_ok;

  elelock_keyenc u_keyenc (
    .tenkey (tenkey),
    .valid  (key_valid),
    .digit  (key_digit)
  );

  assign buf_shift = (code_buf << DIGIT_W) | BUF_W'(key_digit);
  // Count saturates at DIGITS+1, which marks an overflowed entry.
  assign cnt_inc   = (cnt == CNT_OVF) ? cnt : cnt + 1'b1;
  assign tmr_inc   = tmr + 1'b1;
  assign fail_inc  = fail_cnt + 1'b1;
  assign code_ok   = (cnt == CNT_FULL) && (code_buf == secret);
  assign state_o   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_LOCKED;
      lock     <= 1'b1;
      lockout  <= 1'b0;
      fail_cnt <= '0;
      code_buf <= '0;
      cnt      <= '0;
      secret   <= SECRET_INIT;
      tmr      <= '0;
    end else begin
      case (state)
        S_LOCKED: begin
          if (!close && enter) begin
            fail_cnt <= fail_inc;
            tmr      <= '0;
            if (fail_inc == FAIL_LIMIT) begin
              state   <= S_LOCKOUT;
              lockout <= 1'b1;
            end
          end else if (!close && key_valid) begin
            state    <= S_ENTRY;
            code_buf <= buf_shift;
            cnt      <= cnt_inc;
            tmr      <= '0;
          end
        end

        S_ENTRY: begin
          if (close) begin
            state    <= S_LOCKED;
            code_buf <= '0;
            cnt      <= '0;
            tmr      <= '0;
          end else if (enter) begin
            code_buf <= '0;
            cnt      <= '0;
            tmr      <= '0;
            if (code_ok) begin
              state    <= S_OPEN;
              lock     <= 1'b0;
              fail_cnt <= '0;
            end else begin
              fail_cnt <= fail_inc;
              if (fail_inc == FAIL_LIMIT) begin
                state   <= S_LOCKOUT;
                lockout <= 1'b1;
              end else begin
                state <= S_LOCKED;
              end
            end
          end else if (key_valid) begin
            code_buf <= buf_shift;
            cnt      <= cnt_inc;
            tmr      <= '0;
          end else if (tmr == TC_TIMEOUT) begin
            state    <= S_LOCKED;
            code_buf <= '0;
            cnt      <= '0;
            tmr      <= '0;
          end else begin
            tmr <= tmr_inc;
          end
        end

        S_OPEN: begin
          if (close || tmr == TC_RELOCK) begin
            state <= S_LOCKED;
            lock  <= 1'b1;
            tmr   <= '0;
          end else if (prog) begin
            state    <= S_PROGRAM;
            code_buf <= '0;
            cnt      <= '0;
            tmr      <= '0;
          end else begin
            tmr <= tmr_inc;
          end
        end

        S_PROGRAM: begin
          if (close) begin
            state    <= S_LOCKED;
            lock     <= 1'b1;
            code_buf <= '0;
            cnt      <= '0;
            tmr      <= '0;
          end else if (enter) begin
            if (cnt == CNT_FULL) secret <= code_buf;
            state    <= S_OPEN;
            code_buf <= '0;
            cnt      <= '0;
            tmr      <= '0;
          end else if (key_valid) begin
            code_buf <= buf_shift;
            cnt      <= cnt_inc;
            tmr      <= '0;
          end else if (tmr == TC_TIMEOUT) begin
            state    <= S_OPEN;
            code_buf <= '0;
            cnt      <= '0;
            tmr      <= '0;
          end else begin
            tmr <= tmr_inc;
          end
        end

        S_LOCKOUT: begin
          if (tmr == TC_LOCKOUT) begin
            state    <= S_LOCKED;
            lockout  <= 1'b0;
            fail_cnt <= '0;
            tmr      <= '0;
          end else begin
            tmr <= tmr_inc;
          end
        end

        default: begin
          state   <= S_LOCKED;
          lock    <= 1'b1;
          lockout <= 1'b0;
          tmr     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elelock_ctrl.sv
`timescale 1ns/1ps
module tb_elelock_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] tenkey;
  logic       enter;
  logic       close;
  logic       prog;
  logic       lock;
  logic       lockout;
  logic [1:0] fail_cnt;
  logic [2:0] state_o;

  elelock_ctrl #(
    .DIGITS      (4),
    .SECRET_INIT (16'h7341),
    .MAX_FAIL    (3),
    .LOCKOUT_CYC (20),
    .RELOCK_CYC  (10),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tenkey   (tenkey),
    .enter    (enter),
    .close    (close),
    .prog     (prog),
    .lock     (lock),
    .lockout  (lockout),
    .fail_cnt (fail_cnt),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // state codes
  localparam logic [2:0] LCK = 3'd0, ENT = 3'd1, OPN = 3'd2, PRG = 3'd3, LKO = 3'd4;

  typedef struct {
    string      name;
    int         cyc;
    logic [6:0] exp;   // {lock, lockout, fail_cnt[1:0], state[2:0]}
  } exp_t;

  exp_t       sb[$];
  logic [6:0] snap [int];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_mis = 0;

  // One clock: inputs set beforehand are sampled at this edge, outputs are
  // recorded 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    snap[cyc] = {lock, lockout, fail_cnt, state_o};
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int d);
    tenkey = 10'b1 << d;
    step();
    tenkey = '0;
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic code_enter(input logic [31:0] code, input int n);
    for (int i = n - 1; i >= 0; i--) press(int'(code[i*4 +: 4]));
    pulse_enter();
  endtask

  task automatic do_close();
    close = 1'b1;
    step();
    close = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Expectation for the outputs sampled after the most recent edge.
  task automatic expect_now(input string nm, input logic lk, input logic lo,
                            input logic [1:0] f, input logic [2:0] s);
    exp_t e;
    e.name = nm;
    e.cyc  = cyc - 1;
    e.exp  = {lk, lo, f, s};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e; logic [6:0] got;
    do_reset();
    expect_now("reset", 1, 0, 2'd0, LCK);
    idle(12);
    expect_now("idle_locked", 1, 0, 2'd0, LCK);
    tenkey = 10'b0000000011;
    step();
    tenkey = '0;
    expect_now("bad_key_locked", 1, 0, 2'd0, LCK);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = snap[e.cyc]; n_cmp++;
      if (got !== e.exp) begin
        n_mis++;
        $display("FAIL test_reset/%s cyc=%0d: got lock=%b lockout=%b fail=%0d st=%0d, expected lock=%b lockout=%b fail=%0d st=%0d",
                 e.name, e.cyc, got[6], got[5], got[4:3], got[2:0], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
      end
    end
  endtask

  task automatic test_unlock();
    exp_t e; logic [6:0] got;
    press(7);
    expect_now("first_digit", 1, 0, 2'd0, ENT);
    press(3); press(4); press(1);
    expect_now("digits_in", 1, 0, 2'd0, ENT);
    pulse_enter();
    expect_now("unlock", 0, 0, 2'd0, OPN);
    idle(9);
    expect_now("open_hold9", 0, 0, 2'd0, OPN);
    step();
    expect_now("auto_relock10", 1, 0, 2'd0, LCK);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = snap[e.cyc]; n_cmp++;
      if (got !== e.exp) begin
        n_mis++;
        $display("FAIL test_unlock/%s cyc=%0d: got lock=%b lockout=%b fail=%0d st=%0d, expected lock=%b lockout=%b fail=%0d st=%0d",
                 e.name, e.cyc, got[6], got[5], got[4:3], got[2:0], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
      end
    end
  endtask

  task automatic test_lockout();
    exp_t e; logic [6:0] got;
    do_reset();
    code_enter(32'h1111, 4);
    expect_now("fail1", 1, 0, 2'd1, LCK);
    code_enter(32'h1111, 4);
    expect_now("fail2", 1, 0, 2'd2, LCK);
    code_enter(32'h1111, 4);
    expect_now("lockout_enter", 1, 1, 2'd3, LKO);
    code_enter(32'h7341, 4);
    expect_now("lockout_ignores_code", 1, 1, 2'd3, LKO);
    idle(14);
    expect_now("lockout_cyc19", 1, 1, 2'd3, LKO);
    step();
    expect_now("lockout_release", 1, 0, 2'd0, LCK);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = snap[e.cyc]; n_cmp++;
      if (got !== e.exp) begin
        n_mis++;
        $display("FAIL test_lockout/%s cyc=%0d: got lock=%b lockout=%b fail=%0d st=%0d, expected lock=%b lockout=%b fail=%0d st=%0d",
                 e.name, e.cyc, got[6], got[5], got[4:3], got[2:0], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
      end
    end
  endtask

  task automatic test_timeout_abort();
    exp_t e; logic [6:0] got;
    do_reset();
    press(7); press(3);
    idle(7);
    expect_now("pre_timeout", 1, 0, 2'd0, ENT);
    step();
    expect_now("timeout", 1, 0, 2'd0, LCK);
    code_enter(32'h41, 2);
    expect_now("short_after_timeout", 1, 0, 2'd1, LCK);
    press(7); press(3); press(4);
    do_close();
    expect_now("close_abort", 1, 0, 2'd1, LCK);
    code_enter(32'h7341, 4);
    expect_now("unlock_after_abort", 0, 0, 2'd0, OPN);
    do_close();
    expect_now("close_open", 1, 0, 2'd0, LCK);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = snap[e.cyc]; n_cmp++;
      if (got !== e.exp) begin
        n_mis++;
        $display("FAIL test_timeout_abort/%s cyc=%0d: got lock=%b lockout=%b fail=%0d st=%0d, expected lock=%b lockout=%b fail=%0d st=%0d",
                 e.name, e.cyc, got[6], got[5], got[4:3], got[2:0], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
      end
    end
  endtask

  task automatic test_program();
    exp_t e; logic [6:0] got;
    do_reset();
    code_enter(32'h7341, 4);
    prog = 1'b1; step(); prog = 1'b0;
    expect_now("program_enter", 0, 0, 2'd0, PRG);
    press(2); press(5); press(8); press(0);
    expect_now("program_digits", 0, 0, 2'd0, PRG);
    pulse_enter();
    expect_now("program_done", 0, 0, 2'd0, OPN);
    do_close();
    expect_now("relock", 1, 0, 2'd0, LCK);
    code_enter(32'h7341, 4);
    expect_now("old_secret_rejected", 1, 0, 2'd1, LCK);
    code_enter(32'h2580, 4);
    expect_now("new_secret_unlocks", 0, 0, 2'd0, OPN);
    prog = 1'b1; step(); prog = 1'b0;
    press(2);
    idle(7);
    expect_now("program_pre_timeout", 0, 0, 2'd0, PRG);
    step();
    expect_now("program_timeout", 0, 0, 2'd0, OPN);
    idle(9);
    expect_now("open_after_prog9", 0, 0, 2'd0, OPN);
    step();
    expect_now("relock_after_prog", 1, 0, 2'd0, LCK);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = snap[e.cyc]; n_cmp++;
      if (got !== e.exp) begin
        n_mis++;
        $display("FAIL test_program/%s cyc=%0d: got lock=%b lockout=%b fail=%0d st=%0d, expected lock=%b lockout=%b fail=%0d st=%0d",
                 e.name, e.cyc, got[6], got[5], got[4:3], got[2:0], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
      end
    end
  endtask

  task automatic test_edge_inputs();
    exp_t e; logic [6:0] got;
    do_reset();
    press(7);
    tenkey = 10'b0000000011; step(); tenkey = '0;
    press(3); press(4); press(1);
    pulse_enter();
    expect_now("bad_key_not_shifted", 0, 0, 2'd0, OPN);
    do_close();
    code_enter(32'h73419, 5);
    expect_now("overflow_rejected", 1, 0, 2'd1, LCK);
    press(7); press(3); press(4); press(1);
    tenkey = 10'b1 << 9; enter = 1'b1; step(); tenkey = '0; enter = 1'b0;
    expect_now("key_with_enter", 0, 0, 2'd0, OPN);
    do_close();
    press(7); press(3); press(4); press(1);
    close = 1'b1; enter = 1'b1; step(); close = 1'b0; enter = 1'b0;
    expect_now("close_beats_enter", 1, 0, 2'd0, LCK);
    pulse_enter();
    expect_now("empty_enter_fails", 1, 0, 2'd1, LCK);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = snap[e.cyc]; n_cmp++;
      if (got !== e.exp) begin
        n_mis++;
        $display("FAIL test_edge_inputs/%s cyc=%0d: got lock=%b lockout=%b fail=%0d st=%0d, expected lock=%b lockout=%b fail=%0d st=%0d",
                 e.name, e.cyc, got[6], got[5], got[4:3], got[2:0], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [6:0] got;
    do_reset();
    code_enter(32'h7341, 4);
    prog = 1'b1; step(); prog = 1'b0;
    press(2); press(5);
    do_reset();
    expect_now("mid_reset", 1, 0, 2'd0, LCK);
    code_enter(32'h7341, 4);
    expect_now("secret_restored", 0, 0, 2'd0, OPN);
    do_close();
    code_enter(32'h1111, 4);
    expect_now("fail_before_reset", 1, 0, 2'd1, LCK);
    do_reset();
    expect_now("fail_cleared_by_reset", 1, 0, 2'd0, LCK);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = snap[e.cyc]; n_cmp++;
      if (got !== e.exp) begin
        n_mis++;
        $display("FAIL test_reset_mid/%s cyc=%0d: got lock=%b lockout=%b fail=%0d st=%0d, expected lock=%b lockout=%b fail=%0d st=%0d",
                 e.name, e.cyc, got[6], got[5], got[4:3], got[2:0], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    tenkey = '0;
    enter  = 1'b0;
    close  = 1'b0;
    prog   = 1'b0;
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout_abort();
    test_program();
    test_edge_inputs();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
